// File: rtl/can_bit_destuffer.sv
// ---------------------------------------------------------------------------
// can_bit_destuffer
//
// Sits behind the baud recovery block. Samples rx once per bit on the rising
// edge of the recovered baud clock. It tracks bus integration, idle and
// start-of-frame. It removes CAN stuff bits, flags stuff and sync errors, and
// hands the frame parser one-clk bit strobes.
//
// Ports
//   clk        system clock (same domain as the baud generator)
//   rst        synchronous, active-high reset
//   baud       recovered baud clock; rising edge marks the sample point
//   lock       baud generator lock flag; loss of lock aborts a frame
//   rx         synchronised CAN rx, 1 = recessive
//   destuff_en 1 = remove/check stuff bits, 0 = pass every bit through
//   bit_valid  one-clk strobe, bit_out carries a data bit
//   bit_out    destuffed bit value (0 when bit_valid is low)
//   sof        one-clk strobe with the bit_valid of the SOF bit
//   frame_end  one-clk strobe, IDLE_BITS recessive samples seen in a frame
//   stuff_err  one-clk strobe, stuff bit equal to the preceding run
//   sync_err   one-clk strobe, lock lost while in a frame
//   bus_idle   level, high while the block sits in IDLE
//
// Parameters: IDLE_BITS must be below 2**CNT_W so that the saturating
// counters can actually reach it.
// ---------------------------------------------------------------------------
module can_bit_destuffer #(
   parameter int STUFF_LEN = 5,
   parameter int IDLE_BITS = 11,
   parameter int CNT_W     = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic baud,
   input  logic lock,
   input  logic rx,
   input  logic destuff_en,
   output logic bit_valid,
   output logic bit_out,
   output logic sof,
   output logic frame_end,
   output logic stuff_err,
   output logic sync_err,
   output logic bus_idle
);

   typedef enum logic [1:0] {
      INTEGRATE = 2'd0,
      IDLE      = 2'd1,
      FRAME     = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] IDLE_C  = CNT_W'(IDLE_BITS);
   localparam logic [CNT_W-1:0] STUFF_C = CNT_W'(STUFF_LEN);

   state_t           state, state_d;
   logic [CNT_W-1:0] rec_cnt, rec_d;
   logic [CNT_W-1:0] run_len, run_d;
   logic             run_val, run_val_d;
   logic             baud_q;
   logic             armed;
   logic             rise;
   logic [CNT_W-1:0] rec_inc, run_inc;
   logic             stuff_slot;

   logic bv_d, bo_d, sof_d, fe_d, se_d, sy_d;

   // baud_q is cleared by reset, so a baud level that is already high in the
   // first clk after reset would look like a rise. armed masks that clk.
   assign rise = baud & ~baud_q & armed;

   // Saturating increments; the counters never wrap.
   assign rec_inc = (rec_cnt == CNT_MAX) ? rec_cnt : rec_cnt + CNT_ONE;
   assign run_inc = (run_len == CNT_MAX) ? run_len : run_len + CNT_ONE;

   // This sample position holds a stuff bit. The run is tracked even while
   // destuffing is off, so checking resumes from the current run.
   assign stuff_slot = destuff_en & (run_len == STUFF_C);

   // -------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INTEGRATE;
         rec_cnt   <= '0;
         run_len   <= '0;
         run_val   <= 1'b0;
         baud_q    <= 1'b0;
         armed     <= 1'b0;
         bit_valid <= 1'b0;
         bit_out   <= 1'b0;
         sof       <= 1'b0;
         frame_end <= 1'b0;
         stuff_err <= 1'b0;
         sync_err  <= 1'b0;
         bus_idle  <= 1'b0;
      end else begin
         state     <= state_d;
         rec_cnt   <= rec_d;
         run_len   <= run_d;
         run_val   <= run_val_d;
         baud_q    <= baud;
         armed     <= 1'b1;
         bit_valid <= bv_d;
         bit_out   <= bo_d;
         sof       <= sof_d;
         frame_end <= fe_d;
         stuff_err <= se_d;
         sync_err  <= sy_d;
         bus_idle  <= (state_d == IDLE);
      end
   end

   // -------------------------------------------------------------------
   // Next-state and output decode
   // -------------------------------------------------------------------
   always_comb begin
      state_d   = state;
      rec_d     = rec_cnt;
      run_d     = run_len;
      run_val_d = run_val;
      bv_d      = 1'b0;
      bo_d      = 1'b0;
      sof_d     = 1'b0;
      fe_d      = 1'b0;
      se_d      = 1'b0;
      sy_d      = 1'b0;

      case (state)
         INTEGRATE: begin
            if (rise) begin
               if (rx) begin
                  rec_d = rec_inc;
                  if (rec_inc == IDLE_C) state_d = IDLE;
               end else begin
                  rec_d = '0;
               end
            end
         end

         IDLE: begin
            // SOF is the first dominant sample; it opens a dominant run of 1.
            if (rise && !rx) begin
               state_d   = FRAME;
               sof_d     = 1'b1;
               bv_d      = 1'b1;
               bo_d      = 1'b0;
               run_val_d = 1'b0;
               run_d     = CNT_ONE;
               rec_d     = '0;
            end
         end

         FRAME: begin
            // Loss of lock wins over a coincident sample.
            if (!lock) begin
               sy_d    = 1'b1;
               state_d = INTEGRATE;
               rec_d   = '0;
            end else if (rise) begin
               if (stuff_slot && (rx == run_val)) begin
                  se_d    = 1'b1;
                  state_d = INTEGRATE;
                  rec_d   = '0;
               end else begin
                  if (stuff_slot) begin
                     // Valid stuff bit: dropped, but it starts a new run.
                     run_val_d = rx;
                     run_d     = CNT_ONE;
                  end else begin
                     bv_d = 1'b1;
                     bo_d = rx;
                     if (rx == run_val) begin
                        run_d = run_inc;
                     end else begin
                        run_val_d = rx;
                        run_d     = CNT_ONE;
                     end
                  end
                  // The recessive count includes stuff bits. End of frame
                  // still delivers this clk's bit_valid.
                  rec_d = rx ? rec_inc : '0;
                  if (rx && (rec_inc == IDLE_C)) begin
                     fe_d    = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
         end

         default: state_d = INTEGRATE;
      endcase
   end

endmodule

// File: tb/tb_can_bit_destuffer.sv
// ---------------------------------------------------------------------------
// tb_can_bit_destuffer
//
// Every clk, the bench compares the DUT outputs with a behavioural model. The
// model keeps the frame's sample history in a queue. It derives run length
// and recessive count by scanning that history. A bit-level table holds
// directed vectors with expected per-bit results. Hand sequences cover reset
// behaviour. A randomized phase with jittered baud, lock drops, destuff_en
// toggles and resets runs against the same model.
// ---------------------------------------------------------------------------
module tb_can_bit_destuffer;

   localparam int STUFF_LEN = 5;
   localparam int IDLE_BITS = 11;
   localparam int M_INT = 0, M_IDLE = 1, M_FRM = 2;

   logic clk = 1'b0;
   logic rst = 1'b1, baud = 1'b0, lock = 1'b1, rx = 1'b1, destuff_en = 1'b1;
   logic bit_valid, bit_out, sof, frame_end, stuff_err, sync_err, bus_idle;

   int ncmp = 0;
   int nfail = 0;

   can_bit_destuffer #(.STUFF_LEN(STUFF_LEN), .IDLE_BITS(IDLE_BITS), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .baud(baud), .lock(lock), .rx(rx),
      .destuff_en(destuff_en), .bit_valid(bit_valid), .bit_out(bit_out),
      .sof(sof), .frame_end(frame_end), .stuff_err(stuff_err),
      .sync_err(sync_err), .bus_idle(bus_idle)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int m_mode = M_INT;
   bit m_bq = 1'b0, m_arm = 1'b0;
   int icnt = 0;
   bit fhist[$];
   bit e_v, e_b, e_s, e_fe, e_se, e_sy, e_idle;

   function automatic int trail_eq(input bit v);
      int n = 0;
      for (int i = fhist.size() - 1; i >= 0; i--) begin
         if (fhist[i] != v) break;
         n++;
      end
      return n;
   endfunction

   task automatic model_step();
      bit r, last;
      int run;
      {e_v, e_b, e_s, e_fe, e_se, e_sy} = '0;
      if (rst) begin
         m_mode = M_INT; m_bq = 0; m_arm = 0; icnt = 0; fhist.delete();
         e_idle = 0;
         return;
      end
      r = baud && !m_bq && m_arm;
      m_bq = baud;
      m_arm = 1;
      if (m_mode == M_FRM && !lock) begin
         e_sy = 1; m_mode = M_INT; icnt = 0;
      end else if (r) begin
         case (m_mode)
            M_INT: begin
               icnt = rx ? icnt + 1 : 0;
               if (icnt >= IDLE_BITS) m_mode = M_IDLE;
            end
            M_IDLE: if (!rx) begin
               m_mode = M_FRM; fhist.delete(); fhist.push_back(1'b0);
               e_v = 1; e_b = 0; e_s = 1;
            end
            default: begin
               last = fhist[fhist.size() - 1];
               run = trail_eq(last);
               if (run > 15) run = 15;
               if (destuff_en && run == STUFF_LEN && rx == last) begin
                  e_se = 1; m_mode = M_INT; icnt = 0;
               end else begin
                  if (!(destuff_en && run == STUFF_LEN)) begin e_v = 1; e_b = rx; end
                  fhist.push_back(rx);
                  if (fhist.size() > 32) void'(fhist.pop_front());
                  if (trail_eq(1'b1) >= IDLE_BITS) begin e_fe = 1; m_mode = M_IDLE; end
               end
            end
         endcase
      end
      e_idle = (m_mode == M_IDLE);
   endtask

   // ---------------- per-clk step and checks ----------------
   bit acc_v, acc_b, acc_s, acc_fe, acc_se, acc_sy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s @%0t act=%0h exp=%0h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      logic [6:0] act, exp;
      model_step();
      @(posedge clk);
      #1;
      act = {bit_valid, bit_valid & bit_out, sof, frame_end, stuff_err, sync_err, bus_idle};
      exp = {e_v, e_v & e_b, e_s, e_fe, e_se, e_sy, e_idle};
      check("model", 32'(act), 32'(exp));
      acc_v |= bit_valid; if (bit_valid) acc_b = bit_out;
      acc_s |= sof; acc_fe |= frame_end; acc_se |= stuff_err; acc_sy |= sync_err;
   endtask

   // One bit period: baud high for 2 clks, low for 2 clks.
   task automatic send_bit(input logic r, input logic lk, input logic den);
      rx = r; lock = lk; destuff_en = den;
      {acc_v, acc_b, acc_s, acc_fe, acc_se, acc_sy} = '0;
      for (int i = 0; i < 4; i++) begin
         baud = (i < 2);
         tick();
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic rx, lock, den;
      logic v, b, s, fe, se, sy, idle;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input logic r, lk, den, v, b, s, fe, se, sy, idle);
      vec_t t;
      t.rx = r; t.lock = lk; t.den = den; t.v = v; t.b = b; t.s = s;
      t.fe = fe; t.se = se; t.sy = sy; t.idle = idle;
      tbl.push_back(t);
   endfunction

   initial begin
      vec_t t;
      int burst;

      // integrate: 11 recessive -> idle after the 11th, no bit_valid
      for (int i = 0; i < 11; i++) add(1, 1, 1, 0, 0, 0, 0, 0, 0, i == 10);
      // SOF then 1,0,1
      add(0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
      add(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
      add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      add(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
      // 5 dominant, stuff 1 dropped, then 0 delivered
      for (int i = 0; i < 5; i++) add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      // 5 recessive then a recessive stuff bit -> stuff_err
      for (int i = 0; i < 5; i++) add(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
      add(1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
      // back through integration
      for (int i = 0; i < 11; i++) add(1, 1, 1, 0, 0, 0, 0, 0, 0, i == 10);
      // new frame, destuffing off, 11 recessive -> frame_end on the 11th
      add(0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
      add(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
      add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 11; i++) add(1, 1, 0, 1, 1, 0, i == 10, 0, 0, i == 10);
      // frame then lock loss on a sample cycle -> sync_err, no bit_valid
      add(0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
      add(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);

      // reset
      rst = 1; baud = 0; rx = 1;
      tick(); tick();
      check("reset_outputs", 32'({bit_valid, bit_out, sof, frame_end, stuff_err, sync_err, bus_idle}), 0);
      rst = 0;
      tick(); tick();

      for (int i = 0; i < tbl.size(); i++) begin
         t = tbl[i];
         send_bit(t.rx, t.lock, t.den);
         check($sformatf("vec%0d", i),
               32'({acc_v, acc_b, acc_s, acc_fe, acc_se, acc_sy, bus_idle}),
               32'({t.v, t.b, t.s, t.fe, t.se, t.sy, t.idle}));
      end
      lock = 1; destuff_en = 1;

      // rst mid-frame: all outputs 0 on the next clk
      for (int i = 0; i < 11; i++) send_bit(1, 1, 1);
      send_bit(0, 1, 1);
      send_bit(0, 1, 1);
      rx = 0; baud = 0; tick();
      baud = 1; rst = 1; tick();
      check("rst_midframe", 32'({bit_valid, bit_out, sof, frame_end, stuff_err, sync_err, bus_idle}), 0);
      // baud already high in the first clk after reset: not a sample
      rst = 0; rx = 1; tick();
      baud = 0; tick();
      for (int i = 0; i < 10; i++) send_bit(1, 1, 1);
      check("post_rst_edge_ignored", 32'(bus_idle), 0);
      send_bit(1, 1, 1);
      check("post_rst_idle", 32'(bus_idle), 1);

      // randomized phase
      burst = 0;
      for (int n = 0; n < 2000; n++) begin
         int p, hi;
         p = $urandom_range(6, 2);
         hi = $urandom_range(p - 1, 1);
         if (burst > 0) begin rx = 1; burst--; end
         else begin
            rx = 1'($urandom_range(1, 0));
            if ($urandom % 30 == 0) burst = 13;
         end
         if ($urandom % 60 == 0) destuff_en = ~destuff_en;
         for (int c = 0; c < p; c++) begin
            baud = (c < hi);
            lock = ($urandom % 120 != 0);
            rst = ($urandom % 900 == 0);
            tick();
         end
      end
      rst = 0; lock = 1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
